seq_mul_unit: RTL

Parametrised multi-cycle shift-add multiplier for the ALU datapath: accepts two WIDTH-bit operands on a start pulse, retires one multiplier bit per clock, and presents a 2·WIDTH-bit product with a one-cycle done pulse. It supports both two's-complement and unsigned operands, selected per operation. The ALU uses it where a full combinational array costs too much area, trading it for WIDTH+1 cycles of latency.

---
 rtl/mul_pkg.sv | 15 +
 rtl/seq_mul_ctrl.sv | 67 ++++++
 rtl/seq_mul_unit.sv | 71 +++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width for a WIDTH-bit multiplier; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE/RUN/DONE FSM, bit counter,
// and the ready/done handshake plus datapath enables.
module seq_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic ready,
    output logic done,
    output logic accept,
    output logic step,
    output logic last
);

    localparam int CW = cnt_width(WIDTH);

    state_e          state;
    state_e          state_nxt;
    logic   [CW-1:0] cnt;

    // NOTE: state lives in always_ff with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        done      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                ready = 1'b0;
                step  = 1'b1;
                last  = (cnt == CW'(WIDTH - 1));
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = start & ready;
    end

endmodule

// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier, signed or unsigned per operation; retires
// one multiplier bit per clock and presents a 2*WIDTH-bit product with a done pulse.
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;

    logic             accept;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_nxt;
    logic             signed_q;

    seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ready  (ready),
        .done   (done),
        .accept (accept),
        .step   (step),
        .last   (last)
    );

    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so the
    // final partial product is subtracted rather than added.
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        acc_nxt = (signed_q && last) ? (acc - addend) : (acc + addend);
    end

    // NOTE: all datapath registers, product included, are cleared by reset so
    // an aborted operation leaves no stale result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            signed_q <= 1'b0;
            product  <= '0;
        end else if (accept) begin
            mplier   <= a;
            mcand    <= {{WIDTH{signed_mode & b[WIDTH-1]}}, b};
            acc      <= '0;
            signed_q <= signed_mode;
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) product <= acc_nxt;
        end
    end

endmodule
